// File: rtl/cipher_pkg.sv
// Shared nibble-cipher definitions used by both the encryptor and decryptor sides:
// widths, token layout and the grey/thermometer/one-hot helpers.
package cipher_pkg;

   localparam int NIBBLE_W = 4;
   localparam int HEX_W    = 16;

   typedef struct packed {
      logic [HEX_W-1:0] hex;
      logic             key_err;
   } token_t;

   function automatic logic [NIBBLE_W-1:0] gray2bin(input logic [NIBBLE_W-1:0] g);
      logic [NIBBLE_W-1:0] t;
      t[3] = g[3];
      t[2] = t[3] ^ g[2];
      t[1] = t[2] ^ g[1];
      t[0] = t[1] ^ g[0];
      return t;
   endfunction

   function automatic logic [2:0] popcount4(input logic [NIBBLE_W-1:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Bit k of the result is set when the population count exceeds k.
   function automatic logic [NIBBLE_W-1:0] thermometer(input logic [2:0] pc);
      logic [NIBBLE_W-1:0] th;
      case (pc)
         3'd0:    th = 4'b0000;
         3'd1:    th = 4'b0001;
         3'd2:    th = 4'b0011;
         3'd3:    th = 4'b0111;
         default: th = 4'b1111;
      endcase
      return th;
   endfunction

   function automatic logic [HEX_W-1:0] onehot16(input logic [NIBBLE_W-1:0] idx);
      return 16'h0001 << idx;
   endfunction

endpackage

// File: rtl/cipher_stream_decoder_if.sv
// Token handshake bundle for the decoder: encrypted-nibble input side and
// decoded one-hot output side.
interface cipher_stream_decoder_if;
   import cipher_pkg::*;

   logic [NIBBLE_W-1:0] public_key;
   logic                in_valid;
   logic                in_ready;
   logic [NIBBLE_W-1:0] in_data;
   logic [NIBBLE_W-1:0] in_key;
   logic                out_valid;
   logic                out_ready;
   logic [HEX_W-1:0]    out_hex;
   logic                out_key_err;

   modport master (
      output public_key, in_valid, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_hex, out_key_err
   );

   modport slave (
      input  public_key, in_valid, in_data, in_key, out_ready,
      output in_ready, out_valid, out_hex, out_key_err
   );

endinterface

// File: rtl/cipher_fifo.sv
// Synchronous FIFO with occupancy counter; full/empty come from the level so a
// push into a registered-full FIFO is refused even when a pop happens alongside.
module cipher_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/cipher_stream_decoder.sv
// Receive-side nibble-cipher decryptor: decode into a stage-1 register, then an
// output FIFO. Key checking and the error counter exist only with CIPHER_KEY_CHECK_EN.
module cipher_stream_decoder
   import cipher_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ERRW  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   cipher_stream_decoder_if.slave     bus,
   output logic [ERRW-1:0]            err_count,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

`ifdef CIPHER_KEY_CHECK_EN
   localparam int FW = HEX_W + 1;
`else
   localparam int FW = HEX_W;
`endif

   logic [NIBBLE_W-1:0] grey;
   logic [HEX_W-1:0]    dec_hex;
   logic [FW-1:0]       in_word;
   logic [FW-1:0]       s1_data;
   logic [FW-1:0]       head;
   logic                s1_valid;
   logic                fifo_full;
   logic                fifo_empty;
   logic                accept;
   logic                move;

   assign grey         = bus.in_data ^ bus.in_key ^ bus.public_key;
   assign dec_hex      = onehot16(~gray2bin(grey));
   assign bus.in_ready = !s1_valid || !fifo_full;
   assign accept       = bus.in_valid && bus.in_ready;
   assign move         = s1_valid && !fifo_full;
   assign bus.out_valid = !fifo_empty;

`ifdef CIPHER_KEY_CHECK_EN
   logic   key_err;
   token_t tok_in;
   token_t tok_head;

   assign key_err      = (bus.in_key != thermometer(popcount4(grey)));
   assign tok_in       = '{hex: dec_hex, key_err: key_err};
   assign in_word      = tok_in;
   assign tok_head     = token_t'(head);
   assign bus.out_hex     = fifo_empty ? '0 : tok_head.hex;
   assign bus.out_key_err = fifo_empty ? 1'b0 : tok_head.key_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (accept && key_err && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end
`else
   assign in_word         = dec_hex;
   assign bus.out_hex     = fifo_empty ? '0 : head;
   assign bus.out_key_err = 1'b0;
   assign err_count       = '0;
`endif

   // Accepting only happens when stage 1 is empty or draining this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_data  <= in_word;
      end else if (move) begin
         s1_valid <= 1'b0;
      end
   end

   cipher_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s1_valid),
      .pop   (bus.out_ready),
      .wdata (s1_data),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

endmodule

// File: tb/tb_cipher_stream_decoder.sv
// Directed self-checking bench for cipher_stream_decoder; key-error expectations
// follow CIPHER_KEY_CHECK_EN.
module tb_cipher_stream_decoder;

`ifdef CIPHER_KEY_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] err_count;
   logic [2:0] fifo_level;
   int         checks;
   int         errors;

   cipher_stream_decoder_if bus();

   cipher_stream_decoder #(.DEPTH(4), .ERRW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .err_count  (err_count),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] modelHex(input logic [3:0] d, input logic [3:0] k, input logic [3:0] p);
      logic [3:0] g;
      logic [3:0] b;
      g = d ^ k ^ p;
      for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
      return 16'h0001 << (~b);
   endfunction

   function automatic logic modelErr(input logic [3:0] d, input logic [3:0] k, input logic [3:0] p);
      logic [3:0] g;
      int         pc;
      logic [4:0] th;
      g  = d ^ k ^ p;
      pc = 0;
      for (int i = 0; i < 4; i++) pc += int'(g[i]);
      th = (5'd1 << pc) - 5'd1;
      return ERR_ON & (k != th[3:0]);
   endfunction

   function automatic logic [3:0] greyFor(input int idx);
      logic [3:0] b;
      b = ~4'(idx);
      return b ^ (b >> 1);
   endfunction

   // Drive one token and wait (bounded) for the accepting edge; returns #1 after it.
   task automatic applyStimulus(input logic [3:0] d, input logic [3:0] k, input logic [3:0] p);
      logic taken;
      taken = 1'b0;
      bus.in_data    = d;
      bus.in_key     = k;
      bus.public_key = p;
      bus.in_valid   = 1'b1;
      for (int n = 0; n < 20 && !taken; n++) begin
         taken = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!taken) checkOutput("accept_timeout", 32'(taken), 32'd1);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic popOne();
      bus.out_ready = 1'b1;
      stepCycle();
      bus.out_ready = 1'b0;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] bp_data [5];
      int         got;

      checks = 0;
      errors = 0;
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_key     = '0;
      bus.public_key = '0;
      bus.out_ready  = 1'b0;
      stepCycle();
      stepCycle();
      rst = 1'b0;

      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_level", 32'(fifo_level), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      checkOutput("rst_out_hex", 32'(bus.out_hex), 32'd0);

      // Token A: grey 1111 -> index 5, key matches.
      applyStimulus(4'b0011, 4'b1111, 4'b0011);
      checkOutput("a_valid_n", 32'(bus.out_valid), 32'd0);
      stepCycle();
      checkOutput("a_valid_n1", 32'(bus.out_valid), 32'd1);
      checkOutput("a_hex", 32'(bus.out_hex), 32'h0020);
      checkOutput("a_key_err", 32'(bus.out_key_err), 32'd0);
      stepCycle();
      checkOutput("a_hex_hold", 32'(bus.out_hex), 32'h0020);
      checkOutput("a_level_hold", 32'(fifo_level), 32'd1);
      popOne();
      checkOutput("a_popped", 32'(bus.out_valid), 32'd0);

      // Token B: grey 0000 -> index 15.
      applyStimulus(4'b1010, 4'b0000, 4'b1010);
      stepCycle();
      checkOutput("b_hex", 32'(bus.out_hex), 32'h8000);
      checkOutput("b_key_err", 32'(bus.out_key_err), 32'd0);
      popOne();

      // Token C: grey 1110 -> index 4, key 1110 vs expected 0111.
      applyStimulus(4'b0011, 4'b1110, 4'b0011);
      checkOutput("c_err_count", 32'(err_count), 32'(ERR_ON));
      stepCycle();
      checkOutput("c_hex", 32'(bus.out_hex), 32'h0010);
      checkOutput("c_key_err", 32'(bus.out_key_err), 32'(ERR_ON));
      popOne();

      bus.out_ready = 1'b1;
      for (int i = 0; i < 300; i++) applyStimulus(4'b0011, 4'b1110, 4'b0011);
      checkOutput("sat_err_count", 32'(err_count), ERR_ON ? 32'hFF : 32'h0);
      stepCycle();
      stepCycle();
      checkOutput("sat_drained", 32'(fifo_level), 32'd0);
      bus.out_ready = 1'b0;

      pulseReset();
      checkOutput("rst2_err_count", 32'(err_count), 32'd0);

      // Backpressure: four tokens fill the FIFO, the fifth parks in stage 1.
      bp_data[0] = greyFor(3);
      bp_data[1] = greyFor(7);
      bp_data[2] = greyFor(9);
      bp_data[3] = greyFor(12);
      bp_data[4] = greyFor(1);
      for (int i = 0; i < 5; i++) applyStimulus(bp_data[i], 4'b0000, 4'b0000);
      checkOutput("bp_level_full", 32'(fifo_level), 32'd4);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_data  = greyFor(6);
      bus.in_valid = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("bp_stall_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_stall_level", 32'(fifo_level), 32'd4);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      got = 0;
      for (int n = 0; n < 20; n++) begin
         if (bus.out_valid) begin
            if (got < 5) begin
               checkOutput($sformatf("bp_hex%0d", got), 32'(bus.out_hex), 32'(modelHex(bp_data[got], 4'b0000, 4'b0000)));
               checkOutput($sformatf("bp_err%0d", got), 32'(bus.out_key_err), 32'(modelErr(bp_data[got], 4'b0000, 4'b0000)));
            end
            got++;
         end
         stepCycle();
      end
      checkOutput("bp_count", 32'(got), 32'd5);
      bus.out_ready = 1'b0;

      // Streaming: one token per index with the consumer always ready.
      bus.out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 16; i++) applyStimulus(greyFor(i), 4'b0000, 4'b0000);
         end
         begin
            for (int w = 0; w < 10 && !bus.out_valid; w++) stepCycle();
            for (int k = 0; k < 16; k++) begin
               checkOutput($sformatf("st_valid%0d", k), 32'(bus.out_valid), 32'd1);
               checkOutput($sformatf("st_hex%0d", k), 32'(bus.out_hex), 32'(16'h0001 << k));
               checkOutput($sformatf("st_err%0d", k), 32'(bus.out_key_err), 32'(modelErr(greyFor(k), 4'b0000, 4'b0000)));
               checkOutput($sformatf("st_level%0d", k), 32'(fifo_level), 32'd1);
               stepCycle();
            end
         end
      join
      stepCycle();
      checkOutput("st_drained", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;

      // Mid-stream reset with tokens in the FIFO and in stage 1.
      for (int i = 0; i < 3; i++) applyStimulus(4'b0011, 4'b1110, 4'b0011);
      checkOutput("mid_level_pre", 32'(fifo_level), 32'd2);
      pulseReset();
      checkOutput("mid_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_level", 32'(fifo_level), 32'd0);
      checkOutput("mid_err_count", 32'(err_count), 32'd0);
      checkOutput("mid_in_ready", 32'(bus.in_ready), 32'd1);
      stepCycle();
      stepCycle();
      checkOutput("mid_discarded", 32'(bus.out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
